bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble: one shift per clock.
- Sits directly upstream of the 4-digit seven-segment scan driver.
- Its 16-bit packed BCD output drives the driver's digit input, bits [15:0]: digit 0 in [3:0] through digit 3 in [15:12].
- Replaces the large combinational converter with a 14-iteration FSM and a start/done handshake.
- An optional internal auto-trigger re-samples the input periodically, so a free-running counter value can be displayed.

Parameters:
- AUTO_PERIOD, 0, auto-trigger period in clk_24m cycles.
  - 0 disables auto-trigger.
  - Values 1..15 are illegal; the implementation does not need to handle them.
- MAX_VAL, 9999, saturation limit. Fixed by the 4-digit output; not to be overridden.

Ports:
- clk_24m  input  1  system clock, 24 MHz; all logic on rising edge.
- rst  input  1  reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  16  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse; bcd_out has just updated.
- bcd_out  output  16  packed BCD result, 4 digits; held between conversions.
- ovf  output  1  bin_in exceeded MAX_VAL on the last conversion; result saturated.

Interface decisions:
- One clock; reset is synchronous and active-high.
- Clock port is clk_24m; reset port is rst.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, bcd_out=16'h0000, ovf=0.
  - Shift register, iteration counter and auto-trigger counter all cleared.
  - Reset mid-conversion aborts it: no done pulse, bcd_out returns to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Trigger = start OR auto_tick.
  - On a trigger edge: load the 30-bit working register with BCD field = 0 and binary field = min(bin_in, 9999) in the low 14 bits.
  - Set a pending ovf flag = (bin_in > 9999).
  - Set iteration counter = 0 and go to SHIFT.
- SHIFT, each cycle:
  - For each of the 4 BCD nibbles: if nibble >= 5, add 3. The nibble adds are independent, not carried between nibbles.
  - Then shift the whole register left by 1.
  - Counter increments. After the 14th shift (counter == 13 on that edge), go to DONE.
- DONE, single cycle:
  - bcd_out <= BCD field; ovf <= pending flag; done <= 1; go to IDLE.
  - done deasserts on the next edge unconditionally.
- Latency:
  - start sampled at edge 0; 14 shifts on edges 1..14; bcd_out/done/ovf update at edge 15.
  - done is high for the cycle after edge 15.
  - busy is high from after edge 0 until after edge 15, inclusive of the SHIFT and DONE cycles.
- Handshake rules:
  - start while busy=1 is ignored; it is not queued.
  - start held high gives back-to-back conversions. In the cycle done=1 the state is already IDLE, so start is accepted and the next result arrives 16 edges after the previous one.
  - bin_in changes after the accepting edge do not affect the running conversion.
- Auto-trigger (AUTO_PERIOD > 0):
  - Counter runs 0..AUTO_PERIOD-1 continuously, independent of state, and wraps.
  - auto_tick=1 when counter == AUTO_PERIOD-1.
  - A tick arriving while busy is dropped.
  - start and auto_tick in the same IDLE cycle produce one conversion.
- Arithmetic:
  - Maximum loaded binary is 9999 (14 bits), so the result never exceeds 16'h9999 and each nibble stays in 0..9.
  - bcd_out is never partially updated; it changes only in DONE.

Test Plan:
- Reset, then start with bin_in=16'd1234 → busy=1 for 15 cycles; done pulses at edge 15 with bcd_out=16'h1234, ovf=0; done low next cycle.
- Converting bin_in=0 → bcd_out=16'h0000. Converting bin_in=9999 → 16'h9999, ovf=0. Converting bin_in=12345 → 16'h9999, ovf=1. A following conversion of 42 → 16'h0042, ovf=0.
- Start 500, change bin_in to 777 at edge 3, pulse start at edge 5 → single done at edge 15 with 16'h0500. Then hold start high → second done at edge 31 with 16'h0777.
- Assert rst for 1 cycle at edge 8 of a conversion of 4321 → no done; busy=0, bcd_out=0; a new start then completes normally at +15.
- AUTO_PERIOD=100, start tied 0, bin_in ramping → done pulses every 100 cycles; each bcd_out equals the BCD of bin_in at the tick edge.
- Randomised sweep of bin_in over 0..65535 against a reference model → exact bcd_out/ovf match; every nibble <= 9.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter.
// One shift per clock, 14 iterations, start/done handshake. It feeds the
// 4-digit seven-segment scan driver (digit 0 in [3:0] .. digit 3 in [15:12]).
// An optional auto-trigger periodically re-samples bin_in for free-running
// display of a counter value.
module bin2bcd_seq #(
  parameter int AUTO_PERIOD = 0,    // 0 disables auto-trigger; 1..15 unsupported
  parameter int MAX_VAL     = 9999  // saturation limit, tied to 4 output digits
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        ovf
);

  localparam int NDIG  = 4;
  localparam int BIN_W = 14;                // 9999 fits in 14 bits
  localparam int WRK_W = NDIG * 4 + BIN_W;  // BCD field on top, binary below

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [WRK_W-1:0]       work;
  logic [WRK_W-1:0]       work_adj;
  logic [3:0]             iter;
  logic                   ovf_pend;
  logic                   auto_tick;
  logic                   trig;
  logic                   in_ovf;
  logic [BIN_W-1:0]       bin_sat;
  logic [NDIG-1:0][3:0]   nib, nib_adj;

  // Auto-trigger counter free-runs regardless of state; ticks are simply
  // ignored unless the FSM is sitting in IDLE.
  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int AW = $clog2(AUTO_PERIOD);
      logic [AW-1:0] acnt;

      // Wrap counter 0..AUTO_PERIOD-1
      always_ff @(posedge clk_24m) begin
        if (rst)                                acnt <= '0;
        else if (acnt == AW'(AUTO_PERIOD - 1))  acnt <= '0;
        else                                    acnt <= acnt + 1'b1;
      end

      assign auto_tick = (acnt == AW'(AUTO_PERIOD - 1));
    end else begin : g_no_auto
      assign auto_tick = 1'b0;
    end
  endgenerate

  assign trig    = start | auto_tick;
  assign in_ovf  = (bin_in > 16'(MAX_VAL));
  assign bin_sat = in_ovf ? BIN_W'(MAX_VAL) : bin_in[BIN_W-1:0];
  assign busy    = (state != IDLE);

  // Per-digit add-3 correction; nibbles are adjusted independently, no carry.
  generate
    for (genvar i = 0; i < NDIG; i++) begin : g_nib
      assign nib[i]     = work[BIN_W + 4*i +: 4];
      assign nib_adj[i] = (nib[i] >= 4'd5) ? nib[i] + 4'd3 : nib[i];
    end
  endgenerate

  assign work_adj = {nib_adj, work[BIN_W-1:0]};

  // State register
  always_ff @(posedge clk_24m) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: 14 shifts, the last taken with iter == 13, then one DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = SHIFT;
      SHIFT:   if (iter == 4'd13) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on trigger, adjust+shift in SHIFT, publish only in DONE
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      work     <= '0;
      iter     <= '0;
      ovf_pend <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            work     <= {{(NDIG*4){1'b0}}, bin_sat};
            ovf_pend <= in_ovf;
            iter     <= '0;
          end
        end
        SHIFT: begin
          work <= {work_adj[WRK_W-2:0], 1'b0};
          iter <= iter + 1'b1;
        end
        DONE: begin
          bcd_out <= work[WRK_W-1:BIN_W];
          ovf     <= ovf_pend;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
